replica_sequencer: RTL and testbench
====================================

Name: replica_sequencer

Overview:
- Per-replica control FSM. It drives the command, opt and rbank inputs of one replica (distance + exchange pair) through repeated annealing iterations.
- Each iteration runs these steps in order:
  - draw a random 2-opt pair (k,l) from an LFSR;
  - launch the distance delta calculation and wait for it;
  - wait for the Metropolis accept decision;
  - if accepted, run the ordering rewrite.
- Every SWAP_INTERVAL iterations it runs a neighbour-replica exchange phase and flips rbank.
- Sits between the top-level run control and the replica instance. The top packs opt_k/opt_l into opt_t.

Parameters:
- CITY_LOG, 6, width of city index (equals replica_pkg city_num_log).
- ITER_W, 16, width of iteration counter.
- SWAP_INTERVAL, 64, iterations between replica-exchange phases (≥1).
- EXEC_CYCLES, 64, cycles the exchange ordering rewrite command is held (≥1).
- SEED, 16'hACE1, LFSR reset value (nonzero).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begin run (ignored unless IDLE)
- iter_num  in  ITER_W  iterations to run; sampled on start
- replica_id_odd  in  1  replica parity; selects swap partner direction
- dist_done  in  1  distance unit finished delta calculation
- accept_valid  in  1  Metropolis decision present
- accept  in  1  1=take move
- c_distance  out  distance_command_t  DIST_NOP / DIST_CALC
- c_exchange  out  exchange_command_t  EX_NOP / EX_OPT / EX_PREV / EX_FOLW
- opt_k  out  CITY_LOG  lower 2-opt index
- opt_l  out  CITY_LOG  upper 2-opt index
- rbank  out  1  active ordering bank
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end
- iter_cnt  out  ITER_W  completed iterations

Behaviour:
- Reset:
  - state=IDLE; c_distance=DIST_NOP; c_exchange=EX_NOP.
  - opt_k=0, opt_l=0, rbank=0, busy=0, done=0, iter_cnt=0, LFSR=SEED.
  - Reset mid-run aborts immediately; no done pulse.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances once per GEN cycle only.
- IDLE:
  - start=1 and iter_num≠0: latch iter_num, clear iter_cnt, busy=1, go GEN.
  - start=1 and iter_num==0: done pulses next cycle; stay IDLE, busy stays 0.
- GEN, 1 cycle:
  - a = LFSR[CITY_LOG-1:0], b = LFSR[2*CITY_LOG-1:CITY_LOG].
  - If a==b: stay GEN one more cycle and redraw.
  - Else opt_k=min(a,b), opt_l=max(a,b); go DIST.
  - opt_k/opt_l are registered and held stable until the next GEN.
- DIST:
  - c_distance=DIST_CALC on the first cycle only, DIST_NOP afterwards.
  - Wait for dist_done; then go DECIDE.
  - dist_done arriving on the launch cycle is accepted.
- DECIDE:
  - Wait for accept_valid.
  - accept=1: go EXEC.
  - accept=0: go NEXT.
- EXEC:
  - c_exchange=EX_OPT for exactly EXEC_CYCLES cycles, counted by an internal down-counter.
  - Then go NEXT.
- NEXT, 1 cycle:
  - iter_cnt+=1.
  - If the new iter_cnt==latched iter_num: go FIN.
  - Else if new iter_cnt mod SWAP_INTERVAL==0: go SWAP.
  - Else go GEN.
  - FIN takes priority over SWAP.
- SWAP, 2 cycles:
  - Cycle 1: c_exchange = EX_FOLW if replica_id_odd==0, else EX_PREV.
  - Cycle 2: c_exchange = the other command.
  - rbank toggles on exit.
  - Then go GEN.
- FIN:
  - done=1 for one cycle; busy=0; go IDLE.
  - iter_cnt holds its final value until the next start.
- Ignored inputs:
  - start while busy is ignored.
  - dist_done or accept_valid outside DIST/DECIDE is ignored.
- iter_cnt never wraps, because the run ends at iter_num.

Optional Feature:
- Macro: REPLICA_SEQ_STAT_EN.
- When defined:
  - Adds outputs accept_cnt (ITER_W) and swap_cnt (ITER_W).
  - Both clear on reset and on an accepted start.
  - accept_cnt increments on each DECIDE→EXEC transition.
  - swap_cnt increments on each SWAP exit.
  - Both saturate at all-ones.
- When undefined: ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset then start, iter_num=3, dist_done 2 cycles after DIST_CALC, accept=1 every time:
  - exactly 3 DIST_CALC pulses and 3 EX_OPT bursts of 64 cycles each;
  - done pulses once; iter_cnt=3; rbank=0.
- SWAP_INTERVAL=2, iter_num=5, accept=0 always:
  - SWAP phases after iterations 2 and 4 only; rbank sequence 0→1→0;
  - no EX_OPT ever; iter_cnt=5.
- replica_id_odd=1 during a SWAP:
  - c_exchange is EX_PREV then EX_FOLW, each for 1 cycle.
- Force the LFSR to a state with equal fields (a==b):
  - GEN takes 2 cycles; the emitted pair has opt_k<opt_l and opt_k≠opt_l.
- start with iter_num=0:
  - done pulses the next cycle; busy stays 0; no commands issued.
- Assert reset during EXEC at cycle 10:
  - next cycle all outputs are at reset values and the state is IDLE;
  - a subsequent start runs normally from iter_cnt=0.

Source files
------------

// File: rtl/replica_sequencer.sv
// Per-replica annealing sequencer: draws 2-opt pairs, steps the distance/exchange pair,
// and runs periodic neighbour-replica exchange. Define REPLICA_SEQ_STAT_EN for accept/swap counters.
module replica_sequencer #(
  parameter int          CITY_LOG      = 6,
  parameter int          ITER_W        = 16,
  parameter int          SWAP_INTERVAL = 64,
  parameter int          EXEC_CYCLES   = 64,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ITER_W-1:0]   iter_num,
  input  logic                replica_id_odd,
  input  logic                dist_done,
  input  logic                accept_valid,
  input  logic                accept,
  output logic                c_distance,
  output logic [1:0]          c_exchange,
  output logic [CITY_LOG-1:0] opt_k,
  output logic [CITY_LOG-1:0] opt_l,
  output logic                rbank,
  output logic                busy,
  output logic                done,
  output logic [ITER_W-1:0]   iter_cnt
`ifdef REPLICA_SEQ_STAT_EN
  ,
  output logic [ITER_W-1:0]   accept_cnt,
  output logic [ITER_W-1:0]   swap_cnt
`endif
);

  localparam logic       DIST_NOP  = 1'b0;
  localparam logic       DIST_CALC = 1'b1;
  localparam logic [1:0] EX_NOP    = 2'd0;
  localparam logic [1:0] EX_OPT    = 2'd1;
  localparam logic [1:0] EX_PREV   = 2'd2;
  localparam logic [1:0] EX_FOLW   = 2'd3;

  localparam int EW = $clog2(EXEC_CYCLES + 1);
  localparam int SW = $clog2(SWAP_INTERVAL + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_GEN, S_LAUNCH, S_WAIT, S_DECIDE, S_EXEC, S_NEXT, S_SWAP1, S_SWAP2, S_FIN
  } state_t;

  state_t              state, next_state;
  logic [15:0]         lfsr;
  logic [15:0]         lfsr_next;
  logic [ITER_W-1:0]   iter_target;
  logic [ITER_W-1:0]   iter_inc;
  logic [EW-1:0]       exec_ctr;
  logic [SW-1:0]       swap_ctr;
  logic [CITY_LOG-1:0] draw_a, draw_b;
  logic                swap_due;
  logic                run_start;
  logic                take_move;

  assign draw_a    = lfsr[CITY_LOG-1:0];
  assign draw_b    = lfsr[2*CITY_LOG-1:CITY_LOG];
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign iter_inc  = iter_cnt + ITER_W'(1);
  assign swap_due  = (swap_ctr == SW'(SWAP_INTERVAL - 1));
  assign run_start = (state == S_IDLE) && start && (iter_num != '0);
  assign take_move = (state == S_DECIDE) && accept_valid && accept;

  // A zero-length run goes straight to FIN so done still pulses while busy stays low.
  always_comb begin
    next_state = state;
    c_distance = DIST_NOP;
    c_exchange = EX_NOP;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) next_state = (iter_num == '0) ? S_FIN : S_GEN;
      end
      S_GEN: begin
        busy = 1'b1;
        if (draw_a != draw_b) next_state = S_LAUNCH;
      end
      S_LAUNCH: begin
        busy       = 1'b1;
        c_distance = DIST_CALC;
        next_state = dist_done ? S_DECIDE : S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (dist_done) next_state = S_DECIDE;
      end
      S_DECIDE: begin
        busy = 1'b1;
        if (accept_valid) next_state = accept ? S_EXEC : S_NEXT;
      end
      S_EXEC: begin
        busy       = 1'b1;
        c_exchange = EX_OPT;
        if (exec_ctr == '0) next_state = S_NEXT;
      end
      S_NEXT: begin
        busy = 1'b1;
        if (iter_inc == iter_target) next_state = S_FIN;
        else if (swap_due)           next_state = S_SWAP1;
        else                         next_state = S_GEN;
      end
      S_SWAP1: begin
        busy       = 1'b1;
        c_exchange = replica_id_odd ? EX_PREV : EX_FOLW;
        next_state = S_SWAP2;
      end
      S_SWAP2: begin
        busy       = 1'b1;
        c_exchange = replica_id_odd ? EX_FOLW : EX_PREV;
        next_state = S_GEN;
      end
      S_FIN: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // The LFSR only steps in GEN, so a repeated draw just costs one more GEN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      lfsr        <= SEED;
      opt_k       <= '0;
      opt_l       <= '0;
      rbank       <= 1'b0;
      iter_cnt    <= '0;
      iter_target <= '0;
      exec_ctr    <= '0;
      swap_ctr    <= '0;
    end else begin
      state <= next_state;
      if (run_start) begin
        iter_target <= iter_num;
        iter_cnt    <= '0;
        swap_ctr    <= '0;
      end
      if (state == S_GEN) begin
        lfsr <= lfsr_next;
        if (draw_a != draw_b) begin
          opt_k <= (draw_a < draw_b) ? draw_a : draw_b;
          opt_l <= (draw_a < draw_b) ? draw_b : draw_a;
        end
      end
      if (take_move)
        exec_ctr <= EW'(EXEC_CYCLES - 1);
      else if ((state == S_EXEC) && (exec_ctr != '0))
        exec_ctr <= exec_ctr - EW'(1);
      if (state == S_NEXT) begin
        iter_cnt <= iter_inc;
        swap_ctr <= swap_due ? '0 : swap_ctr + SW'(1);
      end
      if (state == S_SWAP2) rbank <= ~rbank;
    end
  end

`ifdef REPLICA_SEQ_STAT_EN
  // Saturating run statistics, cleared together with iter_cnt on an accepted start.
  always_ff @(posedge clk) begin
    if (reset || run_start) begin
      accept_cnt <= '0;
      swap_cnt   <= '0;
    end else begin
      if (take_move && (accept_cnt != '1)) accept_cnt <= accept_cnt + ITER_W'(1);
      if ((state == S_SWAP2) && (swap_cnt != '1)) swap_cnt <= swap_cnt + ITER_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_replica_sequencer.sv
// Directed bench for replica_sequencer: two instances (default config, and a short swap
// interval with a seed whose first draw repeats), checked against hand-computed values.
module tb_replica_sequencer;

  localparam logic [1:0] EX_NOP  = 2'd0;
  localparam logic [1:0] EX_OPT  = 2'd1;
  localparam logic [1:0] EX_PREV = 2'd2;
  localparam logic [1:0] EX_FOLW = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset0, reset1, start0, start1;
  logic [15:0] iter_num;
  logic        replica_id_odd, dist_done, accept_valid, accept;

  logic        c_distance0, c_distance1;
  logic [1:0]  c_exchange0, c_exchange1;
  logic [5:0]  opt_k0, opt_k1, opt_l0, opt_l1;
  logic        rbank0, rbank1, busy0, busy1, done0, done1;
  logic [15:0] iter_cnt0, iter_cnt1;
`ifdef REPLICA_SEQ_STAT_EN
  logic [15:0] accept_cnt0, accept_cnt1, swap_cnt0, swap_cnt1;
`endif

  replica_sequencer dut0 (
    .clk(clk), .reset(reset0), .start(start0), .iter_num(iter_num),
    .replica_id_odd(replica_id_odd), .dist_done(dist_done),
    .accept_valid(accept_valid), .accept(accept),
    .c_distance(c_distance0), .c_exchange(c_exchange0), .opt_k(opt_k0), .opt_l(opt_l0),
    .rbank(rbank0), .busy(busy0), .done(done0), .iter_cnt(iter_cnt0)
`ifdef REPLICA_SEQ_STAT_EN
    , .accept_cnt(accept_cnt0), .swap_cnt(swap_cnt0)
`endif
  );

  replica_sequencer #(.SWAP_INTERVAL(2), .SEED(16'h8000)) dut1 (
    .clk(clk), .reset(reset1), .start(start1), .iter_num(iter_num),
    .replica_id_odd(replica_id_odd), .dist_done(dist_done),
    .accept_valid(accept_valid), .accept(accept),
    .c_distance(c_distance1), .c_exchange(c_exchange1), .opt_k(opt_k1), .opt_l(opt_l1),
    .rbank(rbank1), .busy(busy1), .done(done1), .iter_cnt(iter_cnt1)
`ifdef REPLICA_SEQ_STAT_EN
    , .accept_cnt(accept_cnt1), .swap_cnt(swap_cnt1)
`endif
  );

  logic        sel;
  logic        m_dist, m_rbank, m_busy, m_done;
  logic [1:0]  m_ex;
  logic [5:0]  m_k, m_l;
  logic [15:0] m_iter;
  assign m_dist  = sel ? c_distance1 : c_distance0;
  assign m_ex    = sel ? c_exchange1 : c_exchange0;
  assign m_k     = sel ? opt_k1      : opt_k0;
  assign m_l     = sel ? opt_l1      : opt_l0;
  assign m_rbank = sel ? rbank1      : rbank0;
  assign m_busy  = sel ? busy1       : busy0;
  assign m_done  = sel ? done1       : done0;
  assign m_iter  = sel ? iter_cnt1   : iter_cnt0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int       calc_n = 0, opt_cycles = 0, bursts = 0, bad_bursts = 0, run_len = 0;
  int       swap_n = 0, done_cnt = 0;
  int       calc_cyc[32];
  int       calc_k[32], calc_l[32];
  int       swap_iter[16], swap_rb[16], swap_len[16];
  int       swap_first[16], swap_second[16];
  logic [1:0] dd_pipe = 2'b00;
  logic     prev_sw = 1'b0;

  // Event monitor and distance responder: dist_done returns two cycles after DIST_CALC.
  always @(negedge clk) begin
    dist_done = dd_pipe[1];
    dd_pipe   = {dd_pipe[0], m_dist};
    if (m_dist) begin
      if (calc_n < 32) begin
        calc_cyc[calc_n] = cyc;
        calc_k[calc_n]   = int'(m_k);
        calc_l[calc_n]   = int'(m_l);
      end
      calc_n++;
    end
    if (m_ex == EX_OPT) begin
      opt_cycles++;
      run_len++;
    end else if (run_len != 0) begin
      bursts++;
      if (run_len != 64) bad_bursts++;
      run_len = 0;
    end
    if ((m_ex == EX_PREV) || (m_ex == EX_FOLW)) begin
      if (!prev_sw) begin
        if (swap_n < 16) begin
          swap_first[swap_n] = int'(m_ex);
          swap_iter[swap_n]  = int'(m_iter);
          swap_rb[swap_n]    = int'(m_rbank);
          swap_len[swap_n]   = 1;
        end
        swap_n++;
      end else if ((swap_n > 0) && (swap_n <= 16)) begin
        swap_second[swap_n-1] = int'(m_ex);
        swap_len[swap_n-1]++;
      end
      prev_sw = 1'b1;
    end else begin
      prev_sw = 1'b0;
    end
    if (m_done) done_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  int start_cyc, done_lat, done_busy;
  int cb, ob, bb, xb, sb, db;

  task automatic snapshot();
    cb = calc_n; ob = opt_cycles; bb = bursts; xb = bad_bursts; sb = swap_n; db = done_cnt;
  endtask

  // Pulses start on the selected instance and waits (bounded) for its done pulse.
  task automatic applyStimulus(input logic s, input logic [15:0] n, input logic acc,
                               input logic odd);
    bit seen;
    sel            = s;
    accept         = acc;
    replica_id_odd = odd;
    iter_num       = n;
    @(negedge clk);
    snapshot();
    start_cyc = cyc;
    if (s) start1 = 1'b1; else start0 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      if (m_done) begin
        done_lat  = cyc - start_cyc;
        done_busy = int'(m_busy);
        seen      = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_dist"},  int'(m_dist), 0);
    checkOutput({pfx, "_ex"},    int'(m_ex), int'(EX_NOP));
    checkOutput({pfx, "_k"},     int'(m_k), 0);
    checkOutput({pfx, "_l"},     int'(m_l), 0);
    checkOutput({pfx, "_rbank"}, int'(m_rbank), 0);
    checkOutput({pfx, "_busy"},  int'(m_busy), 0);
    checkOutput({pfx, "_done"},  int'(m_done), 0);
    checkOutput({pfx, "_iter"},  int'(m_iter), 0);
  endtask

  initial begin
    bit seen;
    sel = 1'b0; reset0 = 1'b1; reset1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    iter_num = '0; replica_id_odd = 1'b0; accept_valid = 1'b1; accept = 1'b0;
    repeat (3) @(negedge clk);
    reset0 = 1'b0; reset1 = 1'b0;
    checkResetValues("rst");

    $display("[TB] three accepted iterations, default config");
    applyStimulus(1'b0, 16'd3, 1'b1, 1'b0);
    checkOutput("t1_calcs",      calc_n - cb, 3);
    checkOutput("t1_bursts",     bursts - bb, 3);
    checkOutput("t1_bad_bursts", bad_bursts - xb, 0);
    checkOutput("t1_opt_cycles", opt_cycles - ob, 192);
    checkOutput("t1_swaps",      swap_n - sb, 0);
    checkOutput("t1_done",       done_cnt - db, 1);
    checkOutput("t1_iter",       int'(m_iter), 3);
    checkOutput("t1_rbank",      int'(m_rbank), 0);
    checkOutput("t1_busy",       int'(m_busy), 0);
    checkOutput("t1_k",          calc_k[cb], 33);
    checkOutput("t1_l",          calc_l[cb], 51);
    checkOutput("t1_launch_lat", calc_cyc[cb] - start_cyc, 2);

    $display("[TB] repeated first draw, seed 8000");
    applyStimulus(1'b1, 16'd1, 1'b0, 1'b0);
    checkOutput("t4_launch_lat", calc_cyc[cb] - start_cyc, 3);
    checkOutput("t4_k",          calc_k[cb], 0);
    checkOutput("t4_l",          calc_l[cb], 1);
    checkOutput("t4_iter",       int'(m_iter), 1);
    checkOutput("t4_done",       done_cnt - db, 1);

    $display("[TB] swap interval 2, five rejected iterations");
    applyStimulus(1'b1, 16'd5, 1'b0, 1'b0);
    checkOutput("t2_calcs",      calc_n - cb, 5);
    checkOutput("t2_swaps",      swap_n - sb, 2);
    checkOutput("t2_swap0_iter", swap_iter[sb], 2);
    checkOutput("t2_swap1_iter", swap_iter[sb+1], 4);
    checkOutput("t2_swap0_rb",   swap_rb[sb], 0);
    checkOutput("t2_swap1_rb",   swap_rb[sb+1], 1);
    checkOutput("t2_rbank",      int'(m_rbank), 0);
    checkOutput("t2_first",      swap_first[sb], int'(EX_FOLW));
    checkOutput("t2_second",     swap_second[sb], int'(EX_PREV));
    checkOutput("t2_len",        swap_len[sb], 2);
    checkOutput("t2_opt_cycles", opt_cycles - ob, 0);
    checkOutput("t2_iter",       int'(m_iter), 5);

    $display("[TB] odd replica swap order");
    applyStimulus(1'b1, 16'd3, 1'b0, 1'b1);
    checkOutput("t3_swaps",  swap_n - sb, 1);
    checkOutput("t3_first",  swap_first[sb], int'(EX_PREV));
    checkOutput("t3_second", swap_second[sb], int'(EX_FOLW));
    checkOutput("t3_len",    swap_len[sb], 2);
    checkOutput("t3_rbank",  int'(m_rbank), 1);
    checkOutput("t3_iter",   int'(m_iter), 3);

    $display("[TB] zero-length run");
    applyStimulus(1'b1, 16'd0, 1'b0, 1'b0);
    checkOutput("t5_done_lat", done_lat, 1);
    checkOutput("t5_busy",     done_busy, 0);
    checkOutput("t5_done",     done_cnt - db, 1);
    checkOutput("t5_calcs",    calc_n - cb, 0);
    checkOutput("t5_swaps",    swap_n - sb, 0);
    checkOutput("t5_opt",      opt_cycles - ob, 0);

    $display("[TB] reset in the tenth exchange cycle");
    sel = 1'b0; accept = 1'b1; replica_id_odd = 1'b0; iter_num = 16'd2;
    @(negedge clk);
    snapshot();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_ex == EX_OPT) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) checkOutput("t6_exec_timeout", 0, 1);
    repeat (9) @(negedge clk);
    checkOutput("t6_in_exec", int'(m_ex), int'(EX_OPT));
    reset0 = 1'b1;
    @(negedge clk);
    reset0 = 1'b0;
    checkResetValues("t6");
    repeat (5) @(negedge clk);
    checkOutput("t6_no_done", done_cnt - db, 0);
    checkOutput("t6_idle",    int'(m_busy), 0);
    applyStimulus(1'b0, 16'd1, 1'b1, 1'b0);
    checkOutput("t6_iter",   int'(m_iter), 1);
    checkOutput("t6_done",   done_cnt - db, 1);
    checkOutput("t6_bursts", bursts - bb, 1);
    checkOutput("t6_k",      calc_k[cb], 33);
    checkOutput("t6_l",      calc_l[cb], 51);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
